// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - RV32M funct3 encodings for the operations handled by ex_muldiv_unit
//   - FSM state enum
//   - md_negate: conditional two's-complement negate on a wide vector.
//     Callers zero-extend into MD_MAXW bits and cast the result back down
//     to their own width, so one helper serves operands and products alike.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Widest vector md_negate handles; covers a 2*XLEN product for XLEN <= 128.
  localparam int MD_MAXW = 256;

  function automatic logic [MD_MAXW-1:0] md_negate(input logic [MD_MAXW-1:0] v,
                                                   input logic en);
    md_negate = en ? (~v + MD_MAXW'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_iter_core.sv
// muldiv_iter_core: datapath of the iterative multiplier/divider.
// One 2*XLEN accumulator serves both operations:
//   multiply: {hi, lo} = {partial sum, remaining multiplier bits}; each step
//             adds the multiplicand to hi when lo[0] is set, then shifts right.
//   divide:   {hi, lo} = {remainder, dividend/quotient}; each step shifts left
//             one bit and performs a restoring subtract of the divisor.
// Both start from {0, a_abs}; after XLEN steps acc holds the unsigned
// product, or {remainder, quotient}.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           capture operand magnitudes and operation kind
//   load_div       operation kind at load (1 = divide, 0 = multiply)
//   step           perform one iteration
//   a_abs, b_abs   unsigned operand magnitudes
//   acc            accumulator contents
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_div,
  input  logic              step,
  input  logic [XLEN-1:0]   a_abs,
  input  logic [XLEN-1:0]   b_abs,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_reg;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   b_reg;
  logic              div_reg;

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  always_comb begin
    hi        = acc_reg[2*XLEN-1:XLEN];
    lo        = acc_reg[XLEN-1:0];
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    acc_next  = acc_reg;
    if (div_reg) begin
      // Borrow clear means the divisor fits: keep the difference, quotient bit 1.
      if (!div_diff[XLEN]) begin
        acc_next = {div_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      b_reg   <= '0;
      div_reg <= 1'b0;
    end else if (load) begin
      acc_reg <= {{XLEN{1'b0}}, a_abs};
      b_reg   <= b_abs;
      div_reg <= load_div;
    end else if (step) begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide execute unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes over
// XLEN cycles, followed by one sign-fixup cycle; an opaque tag travels with
// the operation and is returned alongside the result.
// Optional build macro MULDIV_EARLY_OUT_EN: when defined, an operation with a
// zero operand skips the iteration and goes straight to the fixup cycle with
// a precomputed result. Undefined (default): latency is always XLEN+1 cycles.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       upstream presents an operation
//   in_allow_in    unit can accept this cycle
//   in_op          funct3 (MUL..REMU)
//   in_a, in_b     rs1 / rs2 operands
//   in_tag         sideband returned unmodified with the result
//   flush          kill the operation in flight; blocks a same-cycle accept
//   out_valid      result available (held until out_allow_in)
//   out_allow_in   downstream accepts
//   out_result     result
//   out_tag        tag of the finished operation
//   busy           unit is not idle
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_allow_in,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_allow_in,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] counter_reg;
  logic [2:0]       op_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             neg_res_reg;   // negate product / quotient
  logic             neg_rem_reg;   // negate remainder
  logic [XLEN-1:0]  out_result_reg;
  logic [TAG_W-1:0] out_tag_reg;

  logic             accept;
  logic             is_div_op;
  logic             a_signed, b_signed;
  logic             neg_a, neg_b;
  logic             b_zero;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic             neg_res_in, neg_rem_in;

  logic [2*XLEN-1:0] core_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_in;
  logic [XLEN-1:0] early_result_in;
  logic            early_reg;
  logic [XLEN-1:0] early_result_reg;
`endif

  assign in_allow_in = (state_reg == MD_IDLE) | ((state_reg == MD_DONE) & out_allow_in);
  assign accept      = in_valid & in_allow_in & ~flush;
  assign out_valid   = (state_reg == MD_DONE);
  assign busy        = (state_reg != MD_IDLE);
  assign out_result  = out_result_reg;
  assign out_tag     = out_tag_reg;

  // Operand conditioning at accept time.
  always_comb begin
    is_div_op = in_op[2];
    a_signed  = (in_op == MD_MULH) | (in_op == MD_MULHSU) | (in_op == MD_DIV) | (in_op == MD_REM);
    b_signed  = (in_op == MD_MULH) | (in_op == MD_DIV) | (in_op == MD_REM);
    neg_a     = a_signed & in_a[XLEN-1];
    neg_b     = b_signed & in_b[XLEN-1];
    b_zero    = (in_b == '0);
    a_abs     = XLEN'(md_negate(MD_MAXW'(in_a), neg_a));
    b_abs     = XLEN'(md_negate(MD_MAXW'(in_b), neg_b));
    // Division by zero leaves an all-ones quotient that must not be negated;
    // the remainder (which equals |a|) takes the dividend's sign.
    neg_res_in = is_div_op ? ((neg_a ^ neg_b) & ~b_zero) : (neg_a ^ neg_b);
    neg_rem_in = is_div_op & neg_a;
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early_in        = b_zero | (in_a == '0);
    early_result_in = '0;
    if (is_div_op && b_zero) begin
      // in_op[1] separates REM/REMU from DIV/DIVU.
      early_result_in = in_op[1] ? in_a : '1;
    end
  end
`endif

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .load_div(is_div_op),
    .step    (state_reg == MD_CALC),
    .a_abs   (a_abs),
    .b_abs   (b_abs),
    .acc     (core_acc)
  );

  // Sign fixup and result selection, registered during FIX.
  always_comb begin
    prod_fix   = (2*XLEN)'(md_negate(MD_MAXW'(core_acc), neg_res_reg));
    quot_fix   = XLEN'(md_negate(MD_MAXW'(core_acc[XLEN-1:0]), neg_res_reg));
    rem_fix    = XLEN'(md_negate(MD_MAXW'(core_acc[2*XLEN-1:XLEN]), neg_rem_reg));
    fix_result = rem_fix;
    case (op_reg)
      MD_MUL:                       fix_result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_result = quot_fix;
      default:                      fix_result = rem_fix;
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (early_reg) begin
      fix_result = early_result_reg;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= MD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: begin
        if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_next = early_in ? MD_FIX : MD_CALC;
`else
          state_next = MD_CALC;
`endif
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_next = MD_IDLE;
        end else if (counter_reg == CNT_W'(1)) begin
          state_next = MD_FIX;
        end
      end
      MD_FIX: begin
        state_next = flush ? MD_IDLE : MD_DONE;
      end
      MD_DONE: begin
        if (flush) begin
          state_next = MD_IDLE;
        end else if (out_allow_in) begin
          if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
            state_next = early_in ? MD_FIX : MD_CALC;
`else
            state_next = MD_CALC;
`endif
          end else begin
            state_next = MD_IDLE;
          end
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_reg    <= '0;
      op_reg         <= MD_MUL;
      tag_reg        <= '0;
      neg_res_reg    <= 1'b0;
      neg_rem_reg    <= 1'b0;
      out_result_reg <= '0;
      out_tag_reg    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      early_reg        <= 1'b0;
      early_result_reg <= '0;
`endif
    end else begin
      if (accept) begin
        counter_reg <= CNT_W'(XLEN);
        op_reg      <= in_op;
        tag_reg     <= in_tag;
        neg_res_reg <= neg_res_in;
        neg_rem_reg <= neg_rem_in;
`ifdef MULDIV_EARLY_OUT_EN
        early_reg        <= early_in;
        early_result_reg <= early_result_in;
`endif
      end else if (state_reg == MD_CALC) begin
        counter_reg <= counter_reg - CNT_W'(1);
      end
      if ((state_reg == MD_FIX) && !flush) begin
        out_result_reg <= fix_result;
        out_tag_reg    <= tag_reg;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_allow_in;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [36:0] in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_allow_in;
  logic [31:0] out_result;
  logic [36:0] out_tag;
  logic        busy;

  int pass_count  = 0;
  int check_count = 0;

  ex_muldiv_unit #(
    .XLEN (32),
    .TAG_W(37)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_allow_in (in_allow_in),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_allow_in(out_allow_in),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Issues one operation, waits (bounded) for out_valid and returns the
  // latency in cycles after the accept edge. Drains the result when
  // out_allow_in is high so the unit is idle on return.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [36:0] tag, output int lat,
                        output logic [31:0] res, output logic [36:0] otag);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res  = out_result;
    otag = out_tag;
    $display("op=%0d a=%h b=%h tag=%h -> result=%h tag=%h latency=%0d",
             op, a, b, tag, res, otag, lat);
    if (out_allow_in && out_valid) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #12;
    check_count++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_count++;
    check_count++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_count++;
    check_count++;
    if (in_allow_in !== 1'b1) $display("FAIL reset_in_allow_in: got %b expected 1", in_allow_in);
    else pass_count++;
    check_count++;
    if (out_result !== 32'h0) $display("FAIL reset_out_result: got %h expected 0", out_result);
    else pass_count++;
    check_count++;
    if (out_tag !== 37'h0) $display("FAIL reset_out_tag: got %h expected 0", out_tag);
    else pass_count++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int          lat;
    logic [31:0] res;
    logic [36:0] otag;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 37'h1_2345_6789, lat, res, otag);
    check_count++;
    if (lat !== 33) $display("FAIL mul_latency: got %0d expected 33", lat);
    else pass_count++;
    check_count++;
    if (res !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h expected ffffffeb", res);
    else pass_count++;
    check_count++;
    if (otag !== 37'h1_2345_6789) $display("FAIL mul_tag: got %h expected 123456789", otag);
    else pass_count++;
  endtask

  task automatic test_mul_high;
    logic [2:0]  t_op  [3] = '{3'd3, 3'd1, 3'd2};
    logic [31:0] t_a   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
    logic [31:0] t_exp [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    int          lat;
    logic [31:0] res;
    logic [36:0] otag;
    for (int i = 0; i < 3; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 37'(100 + i), lat, res, otag);
      check_count++;
      if (res !== t_exp[i])
        $display("FAIL mulh_result[%0d] op=%0d: got %h expected %h", i, t_op[i], res, t_exp[i]);
      else pass_count++;
    end
  endtask

  task automatic test_div;
    logic [2:0]  t_op  [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] t_a   [6] = '{32'h8000_0000, 32'h8000_0000, 32'd100, 32'd100,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] t_b   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2, 32'd2};
    logic [31:0] t_exp [6] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd100,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF};
    int          lat;
    logic [31:0] res;
    logic [36:0] otag;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 37'(200 + i), lat, res, otag);
      check_count++;
      if (res !== t_exp[i])
        $display("FAIL div_result[%0d] op=%0d: got %h expected %h", i, t_op[i], res, t_exp[i]);
      else pass_count++;
      // Divide by zero still takes the full latency.
      if (t_b[i] == 32'd0) begin
        check_count++;
        if (lat !== 33) $display("FAIL div0_latency[%0d]: got %0d expected 33", i, lat);
        else pass_count++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int          lat;
    logic [31:0] res;
    logic [36:0] otag;
    @(negedge clk);
    out_allow_in = 1'b0;
    run_op(3'd0, 32'd5, 32'd6, 37'h0A_AAAA_AAAA, lat, res, otag);
    check_count++;
    if (res !== 32'd30) $display("FAIL bp_result: got %h expected 1e", res);
    else pass_count++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_count++;
      if (out_valid !== 1'b1 || out_result !== 32'd30 || out_tag !== 37'h0A_AAAA_AAAA || in_allow_in !== 1'b0)
        $display("FAIL bp_hold[%0d]: got valid=%b result=%h tag=%h allow=%b expected 1/1e/aaaaaaaaa/0",
                 c, out_valid, out_result, out_tag, in_allow_in);
      else pass_count++;
    end
    @(negedge clk);
    out_allow_in = 1'b1;
    in_valid     = 1'b1;
    in_op        = 3'd5;
    in_a         = 32'd100;
    in_b         = 32'd7;
    in_tag       = 37'h05_5555_5555;
    #1;
    check_count++;
    if (in_allow_in !== 1'b1) $display("FAIL b2b_allow: got %b expected 1", in_allow_in);
    else pass_count++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_count++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_accept: got valid=%b busy=%b expected 0/1", out_valid, busy);
    else pass_count++;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("op=5 a=00000064 b=00000007 tag=0555555555 -> result=%h tag=%h latency=%0d",
             out_result, out_tag, lat);
    check_count++;
    if (lat !== 33 || out_result !== 32'd14 || out_tag !== 37'h05_5555_5555)
      $display("FAIL b2b_second: got lat=%0d result=%h tag=%h expected 33/e/555555555",
               lat, out_result, out_tag);
    else pass_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush;
    int          lat;
    int          seen;
    logic [31:0] res;
    logic [36:0] otag;
    // Flush together with in_valid: no accept.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_a     = 32'd3;
    in_b     = 32'd3;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    check_count++;
    if (busy !== 1'b0) $display("FAIL flush_blocks_accept: got busy=%b expected 0", busy);
    else pass_count++;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    // Flush ten cycles into the iteration.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd4;
    in_a     = 32'd1000;
    in_b     = 32'd10;
    in_tag   = 37'd77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check_count++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL flush_calc: got busy=%b valid=%b expected 0/0", busy, out_valid);
    else pass_count++;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check_count++;
    if (seen !== 0) $display("FAIL flush_no_result: got out_valid seen=%0d expected 0", seen);
    else pass_count++;
    // Flush in DONE takes priority over a stalled drain.
    @(negedge clk);
    out_allow_in = 1'b0;
    run_op(3'd7, 32'd100, 32'd7, 37'd88, lat, res, otag);
    check_count++;
    if (res !== 32'd2) $display("FAIL flush_done_result: got %h expected 2", res);
    else pass_count++;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check_count++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_allow_in !== 1'b1)
      $display("FAIL flush_done: got valid=%b busy=%b allow=%b expected 0/0/1",
               out_valid, busy, in_allow_in);
    else pass_count++;
    @(negedge clk);
    flush        = 1'b0;
    out_allow_in = 1'b1;
  endtask

  task automatic test_reset_mid;
    int          lat;
    int          seen;
    logic [31:0] res;
    logic [36:0] otag;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_a     = 32'd9;
    in_b     = 32'd9;
    in_tag   = 37'd99;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_count++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_allow_in !== 1'b1 ||
        out_result !== 32'h0 || out_tag !== 37'h0)
      $display("FAIL reset_mid: got busy=%b valid=%b allow=%b result=%h tag=%h expected 0/0/1/0/0",
               busy, out_valid, in_allow_in, out_result, out_tag);
    else pass_count++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check_count++;
    if (seen !== 0) $display("FAIL reset_mid_no_result: got out_valid seen=%0d expected 0", seen);
    else pass_count++;
    run_op(3'd0, 32'd3, 32'd4, 37'd5, lat, res, otag);
    check_count++;
    if (res !== 32'd12 || otag !== 37'd5 || lat !== 33)
      $display("FAIL after_reset_op: got result=%h tag=%h lat=%0d expected c/5/33", res, otag, lat);
    else pass_count++;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_op        = 3'd0;
    in_a         = 32'd0;
    in_b         = 32'd0;
    in_tag       = 37'd0;
    flush        = 1'b0;
    out_allow_in = 1'b1;
    test_reset;
    test_mul;
    test_mul_high;
    test_div;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
